pipe_adder: RTL
===============

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, meaning bits added per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port cin  input  1  carry-in; used only when sub=0.
REQ-010 SHALL have port sub  input  1  0 = a+b+cin; 1 = a-b (a + ~b + 1).
REQ-011 SHALL have port out_valid  output  1  sum/cout hold a result.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result this cycle.
REQ-013 SHALL have port sum  output  WIDTH  result, bits [WIDTH-1:0].
REQ-014 SHALL have port cout  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).

Function
REQ-015 SHALL implement a STAGES-deep pipeline; stage k adds bits [k*CHUNK+CHUNK-1:k*CHUNK] with carry registered from stage k-1.
REQ-016 SHALL skew unconsumed operand chunks and deskew completed sum chunks with registers so that sum is coherent for one transaction.
REQ-017 SHALL accept a transaction on a cycle where in_valid=1 and in_ready=1; sub and cin sampled on the same edge.
REQ-018 SHALL present the result STAGES cycles after acceptance when not stalled (out_valid rises on the STAGES-th edge after acceptance).
REQ-019 SHALL sustain one transaction per cycle when out_ready is held at 1.
REQ-020 SHALL stall the whole pipeline when out_valid=1 and out_ready=0; in_ready = !(out_valid && !out_ready), combinationally.
REQ-021 SHALL hold sum, cout, and out_valid stable throughout a stall.
REQ-022 SHALL propagate empty slots (bubbles) as per-stage valid bits; a bubble reaching the output sets out_valid=0.
REQ-023 SHALL compute results modulo 2^WIDTH; cout is the true carry from the full WIDTH-bit add.
REQ-024 SHALL treat in_valid=0 on an accepting cycle as inserting a bubble, ignoring a, b, cin, and sub.
REQ-025 SHALL fail elaboration (error message) when WIDTH mod CHUNK != 0 or CHUNK < 1.
REQ-026 SHALL degenerate to a single registered stage (latency 1) when CHUNK == WIDTH.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear all stage valid bits, out_valid, sum, cout, and ovf to 0.
REQ-028 SHALL discard all in-flight transactions on reset mid-operation; no partial result appears after release.
REQ-029 SHALL drive in_ready=1 during and after reset; the first acceptance is possible on the first rising edge with rst_n=1.

Configuration
REQ-030 SHALL, when macro PIPE_ADDER_OVF_EN is defined, add port ovf  output  1, the two's-complement signed overflow of the WIDTH-bit result, aligned with sum and held during stalls.
REQ-031 SHALL, when PIPE_ADDER_OVF_EN is undefined, omit port ovf and its logic entirely; all other behaviour is identical.

Verification
REQ-032 SHALL cover, with WIDTH=16 and CHUNK=4: a=FFFF, b=0001, cin=0, sub=0 -> sum=0000, cout=1, out_valid on the 4th edge after acceptance.
REQ-033 SHALL cover: a=0005, b=0007, sub=1 -> sum=FFFE, cout=0; and a=0007, b=0005, sub=1 -> sum=0002, cout=1.
REQ-034 SHALL cover: 8 back-to-back transactions with out_ready=1 -> 8 consecutive out_valid cycles with in-order, correct sums.
REQ-035 SHALL cover: out_ready=0 for 3 cycles while full -> in_ready=0, outputs frozen, no result lost or duplicated after release.
REQ-036 SHALL cover: rst_n pulsed low while 2 transactions are in flight -> out_valid=0 immediately, no stale result after release.
REQ-037 SHALL cover, with PIPE_ADDER_OVF_EN defined: a=7FFF, b=0001, sub=0 -> sum=8000, ovf=1; a=8000, b=0001, sub=1 -> sum=7FFF, ovf=1.

Source files
------------

// File: rtl/pipe_adder.sv
// ---------------------------------------------------------------------------
// pipe_adder
//   Chunked carry-pipelined adder/subtractor with valid/ready handshaking.
//   The WIDTH-bit add is split into STAGES = WIDTH/CHUNK slices. Stage k adds
//   operand bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1.
//   Operand bits not yet consumed travel forward with the carry (skew), and
//   resolved sum bits accumulate stage by stage (deskew). The last stage
//   therefore holds one coherent WIDTH-bit result.
//
//   The whole pipeline advances together. It freezes only when the output
//   holds a result that downstream is not taking.
//
// Parameters
//   WIDTH  operand/sum width in bits (default 16)
//   CHUNK  bits added per pipeline stage (default 4); WIDTH % CHUNK must be 0
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid this cycle
//   in_ready   block accepts operands this cycle (combinational)
//   a, b       operands
//   cin        carry-in, used only when sub = 0
//   sub        0: a + b + cin   1: a - b (a + ~b + 1)
//   out_valid  sum/cout hold a result
//   out_ready  downstream accepts the result this cycle
//   sum        result modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1 (for subtraction, 1 = no borrow)
//   ovf        two's-complement overflow of the result, aligned with sum
//              (present only when PIPE_ADDER_OVF_EN is defined)
//
// Build options
//   PIPE_ADDER_OVF_EN  adds the ovf output and its logic
// ---------------------------------------------------------------------------
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
  localparam bit BAD_CFG = (CHUNK < 1) ? 1'b1 : ((WIDTH % ((CHUNK >= 1) ? CHUNK : 1)) != 0);

  if (BAD_CFG) begin : g_param_err
    $error("pipe_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

`ifdef PIPE_ADDER_OVF_EN
  // Signed overflow: both addends share a sign and the result sign differs.
  // For subtraction the second addend is already ~b, so the same rule holds.
  function automatic logic signed_ovf(input logic sign_a, input logic sign_b,
                                      input logic sign_s);
    return (sign_a == sign_b) && (sign_s != sign_a);
  endfunction
`endif

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // A result parked at the output with no taker freezes every stage.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // Subtraction is a + ~b + 1: fold the inversion and forced carry-in in
  // before stage 0 so every stage is a plain adder.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = WIDTH - k * CHUNK;   // operand bits still pending on entry
    localparam int SW = (k + 1) * CHUNK;     // sum bits resolved on exit

    logic [IW-1:0]  opa_in;
    logic [IW-1:0]  opb_in;
    logic           c_in;
    logic           v_in;
    logic [CHUNK:0] add;
    logic [SW-1:0]  sum_d;

    logic           vld_q;
    logic           cy_q;
    logic [SW-1:0]  sum_q;

    if (k == 0) begin : g_head
      assign opa_in = a;
      assign opb_in = b_eff;
      assign c_in   = c_eff;
      assign v_in   = in_valid;
      assign sum_d  = add[CHUNK-1:0];
    end else begin : g_body
      assign opa_in = g_stage[k-1].g_skew.opa_q;
      assign opb_in = g_stage[k-1].g_skew.opb_q;
      assign c_in   = g_stage[k-1].cy_q;
      assign v_in   = g_stage[k-1].vld_q;
      assign sum_d  = {add[CHUNK-1:0], g_stage[k-1].sum_q};
    end

    assign add = {1'b0, opa_in[CHUNK-1:0]} + {1'b0, opb_in[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, c_in};

    // ---- stage k boundary: valid, carry and resolved sum bits ----
    // A bubble advances its valid bit but leaves the data registers alone.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= v_in;
        if (v_in) begin
          cy_q  <= add[CHUNK];
          sum_q <= sum_d;
        end
      end
    end

    // Operand chunks not consumed yet ride along to later stages.
    if (k < STAGES - 1) begin : g_skew
      logic [IW-CHUNK-1:0] opa_q;
      logic [IW-CHUNK-1:0] opb_q;

      always_ff @(posedge clk) begin
        if (adv && v_in) begin
          opa_q <= opa_in[IW-1:CHUNK];
          opb_q <= opb_in[IW-1:CHUNK];
        end
      end
    end

`ifdef PIPE_ADDER_OVF_EN
    // Only the last stage sees the operand sign bits and the result sign.
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv && v_in) begin
          ovf_q <= signed_ovf(opa_in[IW-1], opb_in[IW-1], add[CHUNK-1]);
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].cy_q;
`ifdef PIPE_ADDER_OVF_EN
  assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
